rcon_sched: RTL

Parametrised AES round-constant scheduler: the successor to the single-mode RCON register. It covers AES-128/192/256, forward key expansion and inverse (decryption) key unrolling, an explicit round counter and start/done control. It sits beside the key-expansion datapath in the TI AES cores and tells the datapath, for every round, whether an RCON is consumed and which value it is.

---
 rtl/rcon_sched.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/rcon_sched.sv
// AES round-constant scheduler for AES-128/192/256 key expansion, forward and inverse.
// Tracks the round index and the RCON of the next consuming round for the key datapath.
module rcon_sched #(
  parameter logic [7:0]  POLY  = 8'h1B,
  parameter int unsigned CNT_W = 4
) (
  input  logic             ClkxCI,
  input  logic             RstxBI,
  input  logic             StartxSI,
  input  logic [1:0]       KeySizexSI,
  input  logic             DecxSI,
  input  logic             NextxSI,
  input  logic             ActivexSI,
  output logic [7:0]       RCONxDO,
  output logic             RconValidxSO,
  output logic [CNT_W-1:0] RoundxDO,
  output logic             BusyxSO,
  output logic             LastRoundxSO,
  output logic             PenultRoundxSO,
  output logic             FinishedxSO
);

  typedef enum logic [1:0] {
    Idle = 2'b00,
    Run  = 2'b01,
    Done = 2'b10
  } state_t;

  localparam logic [1:0] KS_128 = 2'b00;
  localparam logic [1:0] KS_192 = 2'b01;
  localparam logic [1:0] KS_256 = 2'b10;

  // Number of rounds Nr for a (normalised) key size.
  function automatic logic [CNT_W-1:0] numRounds(input logic [1:0] ks);
    logic [CNT_W-1:0] nr;
    case (ks)
      KS_192:  nr = CNT_W'(12);
      KS_256:  nr = CNT_W'(14);
      default: nr = CNT_W'(10);
    endcase
    return nr;
  endfunction

  // RCON of the highest consuming round, the starting point of an inverse walk.
  function automatic logic [7:0] lastRcon(input logic [1:0] ks);
    logic [7:0] rc;
    case (ks)
      KS_192:  rc = 8'h80;
      KS_256:  rc = 8'h40;
      default: rc = 8'h36;
    endcase
    return rc;
  endfunction

  // Does round r draw an RCON for this key size.
  function automatic logic isUsed(input logic [1:0] ks, input logic [CNT_W-1:0] r);
    logic used;
    if (r == '0) begin
      used = 1'b0;
    end else begin
      case (ks)
        KS_192:  used = ((r % CNT_W'(3)) != CNT_W'(2));
        KS_256:  used = ~r[0];
        default: used = 1'b1;
      endcase
    end
    return used;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] rc);
    return {rc[6:0], 1'b0} ^ (rc[7] ? POLY : 8'h00);
  endfunction

  // Multiply by x^-1: undo the reduction when the low bit shows it happened.
  function automatic logic [7:0] xtimeInv(input logic [7:0] rc);
    return rc[0] ? (((rc ^ POLY) >> 1) | 8'h80) : (rc >> 1);
  endfunction

  state_t           StatexDP, StatexDN;
  logic [1:0]       KeySizexDP, KeySizexDN;
  logic             DecxSP, DecxSN;
  logic [CNT_W-1:0] RoundxDP, RoundxDN;
  logic [7:0]       RcxDP, RcxDN;

  logic             usedCur;
  logic [CNT_W-1:0] nrCur;
  logic [CNT_W-1:0] termRound;
  logic             atTerm;
  logic [1:0]       ksLoad;

  assign usedCur   = isUsed(KeySizexDP, RoundxDP);
  assign nrCur     = numRounds(KeySizexDP);
  assign termRound = DecxSP ? '0 : nrCur;
  assign atTerm    = (RoundxDP == termRound);
  assign ksLoad    = (KeySizexSI == 2'b11) ? KS_128 : KeySizexSI;

  // State and schedule registers.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      StatexDP   <= Idle;
      KeySizexDP <= KS_128;
      DecxSP     <= 1'b0;
      RoundxDP   <= '0;
      RcxDP      <= 8'h01;
    end else begin
      StatexDP   <= StatexDN;
      KeySizexDP <= KeySizexDN;
      DecxSP     <= DecxSN;
      RoundxDP   <= RoundxDN;
      RcxDP      <= RcxDN;
    end
  end

  // Next-state logic; Start takes priority over Next in every state.
  always_comb begin
    StatexDN   = StatexDP;
    KeySizexDN = KeySizexDP;
    DecxSN     = DecxSP;
    RoundxDN   = RoundxDP;
    RcxDN      = RcxDP;

    if (StartxSI) begin
      StatexDN   = Run;
      KeySizexDN = ksLoad;
      DecxSN     = DecxSI;
      if (DecxSI) begin
        RoundxDN = numRounds(ksLoad);
        RcxDN    = lastRcon(ksLoad);
      end else begin
        RoundxDN = '0;
        RcxDN    = 8'h01;
      end
    end else begin
      case (StatexDP)
        Run: begin
          if (NextxSI) begin
            if (atTerm) begin
              StatexDN = Done;
            end else if (DecxSP) begin
              RoundxDN = RoundxDP - CNT_W'(1);
              if (usedCur) RcxDN = xtimeInv(RcxDP);
            end else begin
              RoundxDN = RoundxDP + CNT_W'(1);
              if (usedCur) RcxDN = xtime(RcxDP);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Moore decode of the registers; ActivexSI only gates the RCON pair.
  assign BusyxSO        = (StatexDP == Run);
  assign FinishedxSO    = (StatexDP == Done);
  assign RoundxDO       = RoundxDP;
  assign LastRoundxSO   = BusyxSO & atTerm;
  assign PenultRoundxSO = BusyxSO & (DecxSP ? (RoundxDP == CNT_W'(1))
                                            : (RoundxDP == nrCur - CNT_W'(1)));
  assign RconValidxSO   = ActivexSI & BusyxSO & usedCur;
  assign RCONxDO        = RconValidxSO ? RcxDP : 8'h00;

endmodule
